// File: rtl/cuadrado.sv
// Sequential unsigned squarer: base^2 by shift-and-add over WIDTH cycles.
// Latency is data-independent; results are held until the next completion.
module cuadrado #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] cuadrado_res,
    output logic             desborde,
    output logic             ocupado,
    output logic             terminado
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   r_mult;
    logic [WIDTH-1:0]   r_res;
    logic               r_desb;
    logic [CW-1:0]      r_cnt;
    logic               w_last;

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next = r_mult[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iniciar) w_next = S_CALC;
            S_CALC:  if (w_last)  w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ocupado   = (r_state != S_IDLE);
        terminado = (r_state == S_FIN);
    end

    // The final iteration's add is folded into the captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_mult  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_desb  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iniciar) begin
                        r_mcand <= {{WIDTH{1'b0}}, base};
                        r_mult  <= base;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mult  <= r_mult >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res  <= w_acc_next[WIDTH-1:0];
                        r_desb <= |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign cuadrado_res = r_res;
    assign desborde     = r_desb;

endmodule

// File: tb/tb_cuadrado.sv
// Scoreboard bench for cuadrado: driver pushes base^2 expectations,
// monitor pops on each terminado and checks value, overflow, latency and hold.
module tb_cuadrado;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             iniciar = 1'b0;
    logic [WIDTH-1:0] base = '0;
    logic [WIDTH-1:0] cuadrado_res;
    logic             desborde;
    logic             ocupado;
    logic             terminado;

    cuadrado #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .iniciar      (iniciar),
        .base         (base),
        .cuadrado_res (cuadrado_res),
        .desborde     (desborde),
        .ocupado      (ocupado),
        .terminado    (terminado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             desb;
        int               cyc;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] held_res = '0;
    logic             held_desb = 1'b0;
    logic             prev_term = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer square, split into low half and overflow flag.
    task automatic push_exp(input logic [WIDTH-1:0] b, input int acc_cyc);
        longint unsigned sq;
        exp_t e;
        sq     = longint'(b) * longint'(b);
        e.res  = WIDTH'(sq % (64'd1 << WIDTH));
        e.desb = (sq >> WIDTH) != 0;
        e.cyc  = acc_cyc;
        q.push_back(e);
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (rst) begin
            chk("rst_res", cuadrado_res, 0);
            chk("rst_desb", desborde, 0);
            chk("rst_busy", ocupado, 0);
            chk("rst_done", terminado, 0);
            held_res  = '0;
            held_desb = 1'b0;
            prev_term = 1'b0;
        end else begin
            if (terminado) begin
                chk("done_width", prev_term, 0);
                chk("done_busy", ocupado, 1);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", cuadrado_res, e.res);
                    chk("overflow", desborde, e.desb);
                    chk("latency", cyc - e.cyc, WIDTH);
                    held_res  = e.res;
                    held_desb = e.desb;
                end
            end else begin
                if (prev_term) chk("busy_release", ocupado, 0);
                if (cuadrado_res !== held_res) chk("hold_res", cuadrado_res, held_res);
                if (desborde !== held_desb) chk("hold_desb", desborde, held_desb);
            end
            prev_term = terminado;
        end
    end

    task automatic start(input logic [WIDTH-1:0] b);
        @(negedge clk);
        iniciar = 1'b1;
        base    = b;
        push_exp(b, cyc + 1);
        @(negedge clk);
        iniciar = 1'b0;
        base    = WIDTH'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
        @(negedge clk);
    endtask

    initial begin
        int a;
        logic [WIDTH-1:0] vals[7] = '{16'd12, 16'd0, 16'd255, 16'd256, 16'd300, 16'd65535, 16'd1};

        #100;
        @(negedge clk);
        rst = 1'b0;

        foreach (vals[i]) begin
            start(vals[i]);
            wait_done();
        end

        // start ignored mid-computation
        start(16'd5);
        repeat (3) @(negedge clk);
        iniciar = 1'b1;
        base    = 16'd9;
        @(negedge clk);
        iniciar = 1'b0;
        wait_done();
        chk("held_25", cuadrado_res, 25);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            base = ~base;
        end
        chk("held_25_after_idle", cuadrado_res, 25);

        // abort by reset
        start(16'd200);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        chk("abort_done", terminado, 0);
        chk("abort_busy", ocupado, 0);
        chk("abort_res", cuadrado_res, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start(16'd3);
        wait_done();

        // back-to-back with iniciar held high
        @(negedge clk);
        iniciar = 1'b1;
        base    = 16'd7;
        a       = cyc + 1;
        push_exp(16'd7, a);
        repeat (3) @(negedge clk);
        base = 16'd11;
        push_exp(16'd11, a + WIDTH + 2);
        repeat (17) @(negedge clk);
        iniciar = 1'b0;
        wait_done();

        // randomized operands
        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] b;
            b = (i % 2 == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start(b);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
